// File: rtl/mem_pkg.sv
// Shared types and defaults for the MEM-stage access unit and MEM/WB register.
package mem_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned REG_W_DEF  = 5;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic memToReg;
        logic regWrite;
    } wb_ctrl_t;

    localparam wb_ctrl_t WB_BUBBLE = '{memToReg: 1'b0, regWrite: 1'b0};

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register; bubble clears controls, destination and data.
module mem_wb_reg
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned REG_W  = REG_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              loadEn,
    input  logic              bubble,
    input  logic [DATA_W-1:0] readDataIn,
    input  logic [DATA_W-1:0] aluResultIn,
    input  wb_ctrl_t          ctrlIn,
    input  logic [REG_W-1:0]  rdIn,
    output logic [DATA_W-1:0] readDataOut,
    output logic [DATA_W-1:0] aluResultOut,
    output wb_ctrl_t          ctrlOut,
    output logic [REG_W-1:0]  rdOut
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            readDataOut  <= '0;
            aluResultOut <= '0;
            ctrlOut      <= WB_BUBBLE;
            rdOut        <= '0;
        end else if (loadEn) begin
            if (bubble) begin
                readDataOut  <= '0;
                aluResultOut <= '0;
                ctrlOut      <= WB_BUBBLE;
                rdOut        <= '0;
            end else begin
                readDataOut  <= readDataIn;
                aluResultOut <= aluResultIn;
                ctrlOut      <= ctrlIn;
                rdOut        <= rdIn;
            end
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit with single-outstanding req/ack bus.
// Optional wait-state abort is enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned DATA_W         = DATA_W_DEF,
    parameter int unsigned REG_W          = REG_W_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemWrite_in,
    input  logic              MemRead_in,
    input  logic              MemToReg_in,
    input  logic              RegWrite_in,
    input  logic [DATA_W-1:0] AluResult_in,
    input  logic [DATA_W-1:0] WriteData_in,
    input  logic [REG_W-1:0]  Rd_in,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stall_out,
    output logic [DATA_W-1:0] ReadData_out,
    output logic [DATA_W-1:0] AluResult_out,
    output logic              MemToReg_out,
    output logic              RegWrite_out,
    output logic [REG_W-1:0]  Rd_out,
    output logic              misalign_out,
    output logic              timeout_err_out
);

    mem_state_e        state, stateNext;
    logic              reqNext, weNext, misalignNext, stallNext;
    logic [DATA_W-1:0] addrNext, wdataNext;
    wb_ctrl_t          latCtrl, latCtrlNext;
    logic [REG_W-1:0]  latRd, latRdNext;

    logic              wbBubble;
    logic [DATA_W-1:0] wbReadData, wbAluResult;
    wb_ctrl_t          wbCtrl, wbCtrlQ;
    logic [REG_W-1:0]  wbRd;

    logic acc, aligned;
    assign acc     = MemRead_in | MemWrite_in;
    assign aligned = (AluResult_in[1:0] == 2'b00);

`ifdef MEM_TIMEOUT_EN
    logic [7:0] waitCnt, waitCntNext;
    logic       timeoutNext;
`else
    logic unusedTimeoutCfg;
    assign unusedTimeoutCfg = ^32'(TIMEOUT_CYCLES);
    assign timeout_err_out  = 1'b0;
`endif

    // Next-state, bus request and MEM/WB source selection
    always_comb begin
        stateNext    = state;
        stallNext    = 1'b0;
        reqNext      = mem_req;
        weNext       = mem_we;
        addrNext     = mem_addr;
        wdataNext    = mem_wdata;
        latCtrlNext  = latCtrl;
        latRdNext    = latRd;
        misalignNext = 1'b0;
        wbBubble     = 1'b0;
        wbReadData   = '0;
        wbAluResult  = AluResult_in;
        wbCtrl       = '{memToReg: MemToReg_in, regWrite: RegWrite_in};
        wbRd         = Rd_in;
`ifdef MEM_TIMEOUT_EN
        waitCntNext  = waitCnt;
        timeoutNext  = 1'b0;
`endif
        unique case (state)
            MEM_IDLE: begin
                if (acc && aligned) begin
                    stallNext   = 1'b1;
                    stateNext   = MEM_WAIT;
                    reqNext     = 1'b1;
                    weNext      = MemWrite_in;
                    addrNext    = {AluResult_in[DATA_W-1:2], 2'b00};
                    wdataNext   = WriteData_in;
                    latCtrlNext = '{memToReg: MemToReg_in, regWrite: RegWrite_in};
                    latRdNext   = Rd_in;
                    wbBubble    = 1'b1;
`ifdef MEM_TIMEOUT_EN
                    waitCntNext = 8'd0;
`endif
                end else if (acc) begin
                    misalignNext    = 1'b1;
                    wbCtrl.regWrite = 1'b0;
                end
            end
            MEM_WAIT: begin
                if (mem_ack) begin
                    stateNext   = MEM_IDLE;
                    reqNext     = 1'b0;
                    wbCtrl      = latCtrl;
                    wbAluResult = mem_addr;
                    wbRd        = latRd;
                    wbReadData  = mem_we ? '0 : mem_rdata;
                end else begin
                    stallNext = 1'b1;
                    wbBubble  = 1'b1;
`ifdef MEM_TIMEOUT_EN
                    // Ack in the abort cycle takes the branch above instead
                    if (waitCnt == 8'(TIMEOUT_CYCLES - 1)) begin
                        stallNext   = 1'b0;
                        stateNext   = MEM_IDLE;
                        reqNext     = 1'b0;
                        timeoutNext = 1'b1;
                    end else begin
                        waitCntNext = waitCnt + 8'd1;
                    end
`endif
                end
            end
            default: stateNext = MEM_IDLE;
        endcase
        stall_out = stallNext & rst_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= MEM_IDLE;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            latCtrl      <= WB_BUBBLE;
            latRd        <= '0;
            misalign_out <= 1'b0;
        end else begin
            state        <= stateNext;
            mem_req      <= reqNext;
            mem_we       <= weNext;
            mem_addr     <= addrNext;
            mem_wdata    <= wdataNext;
            latCtrl      <= latCtrlNext;
            latRd        <= latRdNext;
            misalign_out <= misalignNext;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waitCnt         <= 8'd0;
            timeout_err_out <= 1'b0;
        end else begin
            waitCnt         <= waitCntNext;
            timeout_err_out <= timeoutNext;
        end
    end
`endif

    mem_wb_reg #(.DATA_W(DATA_W), .REG_W(REG_W)) uMemWb (
        .clk          (clk),
        .rst_n        (rst_n),
        .loadEn       (1'b1),
        .bubble       (wbBubble),
        .readDataIn   (wbReadData),
        .aluResultIn  (wbAluResult),
        .ctrlIn       (wbCtrl),
        .rdIn         (wbRd),
        .readDataOut  (ReadData_out),
        .aluResultOut (AluResult_out),
        .ctrlOut      (wbCtrlQ),
        .rdOut        (Rd_out)
    );

    assign MemToReg_out = wbCtrlQ.memToReg;
    assign RegWrite_out = wbCtrlQ.regWrite;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed plan steps plus random instruction stream.
module tb_mem_access_unit;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MemWrite_in = 1'b0, MemRead_in = 1'b0, MemToReg_in = 1'b0, RegWrite_in = 1'b0;
    logic [31:0] AluResult_in = '0, WriteData_in = '0;
    logic [4:0]  Rd_in = '0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        stall_out;
    logic [31:0] ReadData_out, AluResult_out;
    logic        MemToReg_out, RegWrite_out;
    logic [4:0]  Rd_out;
    logic        misalign_out, timeout_err_out;

    int checks = 0;
    int errors = 0;
    int reqCount = 0;
    int reqExpected = 0;
    logic reqPrev = 1'b0;

    mem_access_unit #(.DATA_W(32), .REG_W(5), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .MemWrite_in(MemWrite_in), .MemRead_in(MemRead_in),
        .MemToReg_in(MemToReg_in), .RegWrite_in(RegWrite_in),
        .AluResult_in(AluResult_in), .WriteData_in(WriteData_in), .Rd_in(Rd_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall_out(stall_out),
        .ReadData_out(ReadData_out), .AluResult_out(AluResult_out),
        .MemToReg_out(MemToReg_out), .RegWrite_out(RegWrite_out), .Rd_out(Rd_out),
        .misalign_out(misalign_out), .timeout_err_out(timeout_err_out)
    );

    always #5 clk = ~clk;

    // Counts distinct bus requests (rising edges of mem_req)
    always @(negedge clk) begin
        if (mem_req && !reqPrev) reqCount++;
        reqPrev = mem_req;
    end

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic checkWord(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkWord(tag, {mem_req, mem_we, stall_out, MemToReg_out, RegWrite_out,
                        misalign_out, timeout_err_out, Rd_out}, 32'd0);
        checkWord({tag, "_addr"}, mem_addr | mem_wdata, 32'd0);
        checkWord({tag, "_wb"}, ReadData_out | AluResult_out, 32'd0);
    endtask

    // One EX/MEM instruction, held while stalled; expected results come from the access rules
    task automatic runInstr(input logic mw, input logic mr, input logic m2r, input logic rw,
                            input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                            input int ackDelay, input logic [31:0] rdata, input logic idleAck);
        bit isMem   = mr | mw;
        bit aligned = (alu[1:0] == 2'b00);
        MemWrite_in = mw; MemRead_in = mr; MemToReg_in = m2r; RegWrite_in = rw;
        AluResult_in = alu; WriteData_in = wd; Rd_in = rd;
        mem_ack = idleAck; mem_rdata = $urandom;
        @(negedge clk);
        if (!isMem || !aligned) begin
            checkBit("stall_pass", stall_out, 1'b0);
            @(posedge clk); #1;
            mem_ack = 1'b0;
            checkBit("req_none", mem_req, 1'b0);
            checkBit("regwrite_pass", RegWrite_out, isMem ? 1'b0 : rw);
            checkBit("memtoreg_pass", MemToReg_out, m2r);
            checkWord("rd_pass", 32'(Rd_out), 32'(rd));
            checkWord("alu_pass", AluResult_out, alu);
            checkWord("rdata_pass", ReadData_out, 32'd0);
            checkBit("misalign", misalign_out, isMem);
        end else begin
            checkBit("stall_issue", stall_out, 1'b1);
            @(posedge clk); #1;
            mem_ack = 1'b0;
            reqExpected++;
            checkBit("req_issue", mem_req, 1'b1);
            checkBit("we_issue", mem_we, mw);
            checkWord("addr_issue", mem_addr, alu);
            if (mw) checkWord("wdata_issue", mem_wdata, wd);
            checkBit("bubble_rw", RegWrite_out, 1'b0);
            checkWord("bubble_rd", 32'(Rd_out), 32'd0);
            for (int i = 0; i < ackDelay; i++) begin
                @(negedge clk);
                checkBit("stall_wait", stall_out, 1'b1);
                @(posedge clk); #1;
                checkBit("req_hold", mem_req, 1'b1);
                checkWord("addr_hold", mem_addr, alu);
                checkBit("bubble_wait", RegWrite_out | MemToReg_out, 1'b0);
            end
            mem_ack = 1'b1; mem_rdata = rdata;
            @(negedge clk);
            checkBit("stall_ack", stall_out, 1'b0);
            @(posedge clk); #1;
            mem_ack = 1'b0; mem_rdata = $urandom;
            checkBit("req_drop", mem_req, 1'b0);
            checkBit("regwrite_ack", RegWrite_out, rw);
            checkBit("memtoreg_ack", MemToReg_out, m2r);
            checkWord("rd_ack", 32'(Rd_out), 32'(rd));
            checkWord("alu_ack", AluResult_out, alu);
            checkWord("rdata_ack", ReadData_out, mw ? 32'd0 : rdata);
            checkBit("misalign_ack", misalign_out, 1'b0);
        end
        checkBit("timeout_idle", timeout_err_out, 1'b0);
    endtask

    initial begin
        // Reset state
        #2;
        checkAllZero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed plan steps
        runInstr(1'b0, 1'b0, 1'b0, 1'b1, 32'h1234, 32'h0, 5'd5, 0, 32'h0, 1'b0);
        runInstr(1'b0, 1'b1, 1'b1, 1'b1, 32'h100, 32'h0, 5'd9, 3, 32'hDEADBEEF, 1'b0);
        runInstr(1'b1, 1'b0, 1'b0, 1'b0, 32'h204, 32'hA5A5A5A5, 5'd0, 0, 32'h0, 1'b0);
        runInstr(1'b0, 1'b1, 1'b1, 1'b1, 32'h102, 32'h0, 5'd3, 0, 32'h0, 1'b0);
        runInstr(1'b0, 1'b0, 1'b0, 1'b1, 32'h55, 32'h0, 5'd4, 0, 32'h0, 1'b1);
        runInstr(1'b1, 1'b1, 1'b1, 1'b1, 32'h308, 32'h0BADF00D, 5'd6, 1, 32'h77777777, 1'b0);

        // Reset asserted mid-WAIT
        MemRead_in = 1'b1; MemWrite_in = 1'b0; RegWrite_in = 1'b1; AluResult_in = 32'h300; Rd_in = 5'd2;
        @(posedge clk); #1;
        reqExpected++;
        checkBit("rst_pre_req", mem_req, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checkAllZero("reset_midwait");
        MemRead_in = 1'b0; RegWrite_in = 1'b0; AluResult_in = '0; Rd_in = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        runInstr(1'b0, 1'b0, 1'b0, 1'b1, 32'hCAFE, 32'h0, 5'd8, 0, 32'h0, 1'b0);

`ifdef MEM_TIMEOUT_EN
        // Abort after TO wait cycles without ack
        MemRead_in = 1'b1; MemWrite_in = 1'b0; RegWrite_in = 1'b1; MemToReg_in = 1'b1;
        AluResult_in = 32'h400; Rd_in = 5'd7;
        @(negedge clk);
        checkBit("to_stall_issue", stall_out, 1'b1);
        @(posedge clk); #1;
        reqExpected++;
        for (int i = 0; i < int'(TO) - 1; i++) begin
            @(negedge clk);
            checkBit("to_stall_wait", stall_out, 1'b1);
            @(posedge clk); #1;
            checkBit("to_no_err_yet", timeout_err_out, 1'b0);
        end
        @(negedge clk);
        checkBit("to_stall_abort", stall_out, 1'b0);
        @(posedge clk); #1;
        checkBit("to_err", timeout_err_out, 1'b1);
        checkBit("to_req_drop", mem_req, 1'b0);
        checkBit("to_bubble_rw", RegWrite_out, 1'b0);
        checkWord("to_bubble_rd", 32'(Rd_out), 32'd0);
        runInstr(1'b0, 1'b0, 1'b0, 1'b1, 32'h99, 32'h0, 5'd1, 0, 32'h0, 1'b0);
`endif

        // Random instruction stream
        for (int n = 0; n < 60; n++) begin
            int kind = int'($urandom_range(0, 3));
            logic [31:0] alu = $urandom;
            logic mw = 1'b0, mr = 1'b0;
            int delay;
`ifdef MEM_TIMEOUT_EN
            delay = int'($urandom_range(0, TO - 1));
`else
            delay = int'($urandom_range(0, 6));
`endif
            if (kind == 1) mr = 1'b1;
            if (kind == 2) mw = 1'b1;
            if (kind == 3) begin mr = 1'b1; mw = 1'b1; end
            if (kind != 0 && $urandom_range(0, 3) != 0) alu[1:0] = 2'b00;
            runInstr(mw, mr, 1'($urandom), 1'($urandom), alu, $urandom, 5'($urandom),
                     delay, $urandom, 1'($urandom));
        end

        @(negedge clk);
        checkWord("req_count", 32'(reqCount), 32'(reqExpected));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
